// File: rtl/draw_pkg.sv
// Shared definitions for the draw pair writer slice.
//   ADDR_W          - framebuffer address width
//   FB_BASE_DEFAULT - default first even address of the write window
//   state_e         - writer FSM states
package draw_pkg;

    localparam int unsigned ADDR_W          = 14;
    localparam int unsigned FB_BASE_DEFAULT = 15872;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

endpackage

// File: rtl/draw_pair_writer_if.sv
// Upstream pair stream: an even/odd address pair with one pixel per address.
//   in_valid       - pair valid (master)
//   in_ready       - writer accepts a pair this cycle (slave)
//   addr_a, addr_b - even / odd framebuffer address
//   data_a, data_b - pixels for addr_a / addr_b
// Modports: master = upstream producer, slave = draw_pair_writer.
interface draw_pair_writer_if #(
    parameter int unsigned DATA_W = 8
);

    logic                        in_valid;
    logic                        in_ready;
    logic [draw_pkg::ADDR_W-1:0] addr_a;
    logic [draw_pkg::ADDR_W-1:0] addr_b;
    logic [DATA_W-1:0]           data_a;
    logic [DATA_W-1:0]           data_b;

    modport master (
        output in_valid, addr_a, addr_b, data_a, data_b,
        input  in_ready
    );

    modport slave (
        input  in_valid, addr_a, addr_b, data_a, data_b,
        output in_ready
    );

endinterface

// File: rtl/draw_addr_check.sv
// Combinational pair validator, compiled only with DRAW_ADDR_CHECK_EN defined.
// A pair is good when addr_a is even, addr_b == addr_a + 1 and addr_a lies in
// [FB_BASE, FB_BASE + 2*PAIR_TOTAL).
//   addr_a, addr_b - candidate address pair
//   pair_ok        - 1 when the pair passes every rule
`ifdef DRAW_ADDR_CHECK_EN
module draw_addr_check
    import draw_pkg::*;
#(
    parameter int unsigned PAIR_TOTAL = 128,
    parameter int unsigned FB_BASE    = FB_BASE_DEFAULT
) (
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    output logic              pair_ok
);

    localparam logic [31:0] WinLo = 32'(FB_BASE);
    localparam logic [31:0] WinHi = 32'(FB_BASE + 2 * PAIR_TOTAL);

    logic [31:0] a_ext;
    logic        succ_ok;

    assign a_ext = 32'(addr_a);
    // One extra bit so addr_a = all-ones cannot wrap onto addr_b = 0.
    assign succ_ok = ({1'b0, addr_b} == ({1'b0, addr_a} + {{ADDR_W{1'b0}}, 1'b1}));
    assign pair_ok = !addr_a[0] && succ_ok && (a_ext >= WinLo) && (a_ext < WinHi);

endmodule
`endif

// File: rtl/draw_pair_writer.sv
// Dual-port framebuffer pair writer. After start it accepts PAIR_TOTAL address
// pairs from upstream and issues one registered dual write strobe per pair.
//   clk, reset         - clock, asynchronous active-low reset
//   start              - one-cycle pulse, begins a segment from IDLE or DONE
//   pair               - upstream pair stream (slave modport)
//   wr_en_*, wr_addr_*, wr_data_* - framebuffer write port A / B
//   pair_count         - pairs written in the current segment
//   done               - segment complete, held until start or reset
//   err                - sticky address-check error
// Optional: DRAW_ADDR_CHECK_EN enables pair validation; bad pairs are
// consumed without a write and set err. Undefined, err is tied to 0.
module draw_pair_writer
    import draw_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned PAIR_TOTAL = 128,
    parameter int unsigned FB_BASE    = FB_BASE_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    draw_pair_writer_if.slave pair,
    output logic              wr_en_a,
    output logic              wr_en_b,
    output logic [ADDR_W-1:0] wr_addr_a,
    output logic [ADDR_W-1:0] wr_addr_b,
    output logic [DATA_W-1:0] wr_data_a,
    output logic [DATA_W-1:0] wr_data_b,
    output logic [7:0]        pair_count,
    output logic              done,
    output logic              err
);

    localparam logic [7:0] PairTotal8 = 8'(PAIR_TOTAL);
    localparam logic [8:0] PairTotal9 = 9'(PAIR_TOTAL);

    state_e            state_q, state_d;
    logic [7:0]        count_q, count_d;
    logic              wr_en_q;
    logic [ADDR_W-1:0] addr_a_q, addr_b_q;
    logic [DATA_W-1:0] data_a_q, data_b_q;
    logic              accept, pair_ok, write;

    // Ready depends on state and count only, so upstream may hold in_valid.
    assign pair.in_ready = (state_q == StRun) && (count_q < PairTotal8);
    assign accept        = pair.in_valid && pair.in_ready;
    assign write         = accept && pair_ok;

`ifdef DRAW_ADDR_CHECK_EN
    logic err_q;

    draw_addr_check #(
        .PAIR_TOTAL (PAIR_TOTAL),
        .FB_BASE    (FB_BASE)
    ) u_addr_check (
        .addr_a  (pair.addr_a),
        .addr_b  (pair.addr_b),
        .pair_ok (pair_ok)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if (accept && !pair_ok) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    logic unused_fb_base;

    // Keeps the window parameter referenced when checking is compiled out.
    assign unused_fb_base = ^32'(FB_BASE);
    assign pair_ok        = 1'b1;
    assign err            = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StRun;
                    count_d = '0;
                end
            end
            StRun: begin
                // in_ready gates writes at PAIR_TOTAL, so the count saturates there.
                if (write) begin
                    count_d = count_q + 8'd1;
                    if (({1'b0, count_q} + 9'd1) == PairTotal9) begin
                        state_d = StDone;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_en_q  <= 1'b0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            data_a_q <= '0;
            data_b_q <= '0;
        end else begin
            wr_en_q <= write;
            if (write) begin
                addr_a_q <= pair.addr_a;
                addr_b_q <= pair.addr_b;
                data_a_q <= pair.data_a;
                data_b_q <= pair.data_b;
            end
        end
    end

    // One strobe flop drives both ports so they can never split.
    assign wr_en_a    = wr_en_q;
    assign wr_en_b    = wr_en_q;
    assign wr_addr_a  = addr_a_q;
    assign wr_addr_b  = addr_b_q;
    assign wr_data_a  = data_a_q;
    assign wr_data_b  = data_b_q;
    assign pair_count = count_q;
    assign done       = (state_q == StDone);

endmodule

// File: tb/tb_draw_pair_writer.sv
// Scoreboard bench for draw_pair_writer: the driver keeps a segment-level
// model and queues expected writes; a negedge monitor checks the DUT.
module tb_draw_pair_writer;

    localparam int unsigned DW = 8;
    localparam int          PT = 128;
    localparam int          FB = 15872;

    typedef struct {
        logic [13:0] a;
        logic [13:0] b;
        logic [7:0]  da;
        logic [7:0]  db;
        int          edge_no;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        wr_en_a, wr_en_b;
    logic [13:0] wr_addr_a, wr_addr_b;
    logic [7:0]  wr_data_a, wr_data_b;
    logic [7:0]  pair_count;
    logic        done, err;

    always #5 clk = ~clk;

    draw_pair_writer_if #(.DATA_W(DW)) pif ();

    draw_pair_writer #(
        .DATA_W     (DW),
        .PAIR_TOTAL (PT),
        .FB_BASE    (FB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .pair       (pif.slave),
        .wr_en_a    (wr_en_a),
        .wr_en_b    (wr_en_b),
        .wr_addr_a  (wr_addr_a),
        .wr_addr_b  (wr_addr_b),
        .wr_data_a  (wr_data_a),
        .wr_data_b  (wr_data_b),
        .pair_count (pair_count),
        .done       (done),
        .err        (err)
    );

    wr_t exp_q[$];
    int  vectors = 0;
    int  miscompares = 0;
    int  edges = 0;

    // Segment-level reference model.
    bit  m_active = 1'b0;
    int  m_cnt = 0;
    bit  m_done = 1'b0;
    bit  m_err = 1'b0;

    logic [13:0] last_a = '0, last_b = '0;
    logic [7:0]  last_da = '0, last_db = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit addr_ok(input logic [13:0] a, input logic [13:0] b);
`ifdef DRAW_ADDR_CHECK_EN
        int ia = int'(a);
        int ib = int'(b);
        return (ia % 2 == 0) && (ib == ia + 1) && (ia >= FB) && (ia < FB + 2 * PT);
`else
        return (a == a) && (b == b);
`endif
    endfunction

    function automatic logic [13:0] pa(input int i);
        return 14'(FB + 2 * i);
    endfunction

    task automatic tick();
        @(posedge clk);
        edges++;
    endtask

    // Called 1 ns after a rising edge; returns 1 ns after the next one.
    task automatic step(input bit s, input bit v, input logic [13:0] a, input logic [13:0] b,
                        input logic [7:0] da, input logic [7:0] db);
        bit exp_ready;
        start        = s;
        pif.in_valid = v;
        pif.addr_a   = a;
        pif.addr_b   = b;
        pif.data_a   = da;
        pif.data_b   = db;
        exp_ready    = m_active && (m_cnt < PT);
        #1;
        check("in_ready", 32'(pif.in_ready), 32'(exp_ready));
        tick();
        if (m_active) begin
            if (v) begin
                if (addr_ok(a, b)) begin
                    exp_q.push_back('{a, b, da, db, edges});
                    m_cnt++;
                    if (m_cnt == PT) begin
                        m_active = 1'b0;
                        m_done   = 1'b1;
                    end
                end else begin
                    m_err = 1'b1;
                end
            end
        end else if (s) begin
            m_active = 1'b1;
            m_cnt    = 0;
            m_done   = 1'b0;
        end
        #1;
    endtask

    task automatic good(input int i);
        step(1'b0, 1'b1, pa(i), pa(i) + 14'd1, 8'($urandom), 8'($urandom));
    endtask

    task automatic idle();
        step(1'b0, 1'b0, '0, '0, '0, '0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        exp_q.delete();
        m_active = 1'b0;
        m_cnt    = 0;
        m_done   = 1'b0;
        m_err    = 1'b0;
        last_a   = '0;
        last_b   = '0;
        last_da  = '0;
        last_db  = '0;
        #1;
        check("rst_wr_en_a", 32'(wr_en_a), 0);
        check("rst_wr_en_b", 32'(wr_en_b), 0);
        check("rst_pair_count", 32'(pair_count), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_in_ready", 32'(pif.in_ready), 0);
        check("rst_wr_addr_a", 32'(wr_addr_a), 0);
        check("rst_wr_data_b", 32'(wr_data_b), 0);
        tick();
        tick();
        #1;
        reset = 1'b1;
    endtask

    always @(negedge clk) begin : monitor
        bit  exp_wr;
        wr_t e;
        if (reset) begin
            // Entries older than this edge were missed; the strobe check reports them.
            while (exp_q.size() > 0 && exp_q[0].edge_no < edges) void'(exp_q.pop_front());
            exp_wr = (exp_q.size() > 0) && (exp_q[0].edge_no == edges);
            check("wr_en_a", 32'(wr_en_a), 32'(exp_wr));
            check("wr_en_b", 32'(wr_en_b), 32'(exp_wr));
            if (exp_wr) begin
                e       = exp_q.pop_front();
                last_a  = e.a;
                last_b  = e.b;
                last_da = e.da;
                last_db = e.db;
            end
            check("wr_addr_a", 32'(wr_addr_a), 32'(last_a));
            check("wr_addr_b", 32'(wr_addr_b), 32'(last_b));
            check("wr_data_a", 32'(wr_data_a), 32'(last_da));
            check("wr_data_b", 32'(wr_data_b), 32'(last_db));
            check("pair_count", 32'(pair_count), 32'(m_cnt));
            check("done", 32'(done), 32'(m_done));
            check("err", 32'(err), 32'(m_err));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [13:0] a, b;
        int          i;
        reset        = 1'b1;
        start        = 1'b0;
        pif.in_valid = 1'b0;
        pif.addr_a   = '0;
        pif.addr_b   = '0;
        pif.data_a   = '0;
        pif.data_b   = '0;
        #2;
        do_reset();

        // Full segment of consecutive pairs, then done.
        step(1'b1, 1'b0, '0, '0, '0, '0);
        for (int k = 0; k < PT; k++) good(k);
        idle();
        idle();

        // Valid held in DONE: no strobes, count stays.
        for (int k = 0; k < 10; k++) good(k);

        // Restart from DONE with a single pair.
        step(1'b1, 1'b0, '0, '0, '0, '0);
        good(0);
        repeat (3) idle();

        // Valid every other cycle until the segment fills; start in RUN ignored.
        for (int k = 0; k < 300; k++) begin
            if (k % 2 == 0) good((k / 2) % PT);
            else step(k == 7, 1'b0, pa(1), pa(1) + 14'd1, 8'hAA, 8'h55);
        end

        // Misaligned pair: written without checking, rejected with it.
        step(1'b1, 1'b0, '0, '0, '0, '0);
        step(1'b0, 1'b1, 14'd15873, 14'd15874, 8'h11, 8'h22);
        repeat (5) idle();

        // Abort mid-segment with reset; nothing written until a new start.
        for (int k = 0; k < 50; k++) good(k);
        do_reset();
        for (int k = 0; k < 10; k++) good(k);

        // Randomized traffic with occasional starts and off-window pairs.
        step(1'b1, 1'b0, '0, '0, '0, '0);
        for (int k = 0; k < 700; k++) begin
            i = int'($urandom_range(0, PT - 1));
            a = pa(i);
            b = a + 14'd1;
            if ($urandom_range(0, 7) == 0) begin
                a = 14'($urandom);
                b = 14'($urandom);
            end
            step($urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1, a, b,
                 8'($urandom), 8'($urandom));
        end
        repeat (3) idle();
        check("queue_drained", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
